// File: rtl/icache_sa_pkg.sv
// Shared types and address-field width helpers for the set-associative instruction cache.
package icache_sa_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REFILL,
    FLUSH
  } state_t;

  function automatic int unsigned off_width(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic int unsigned word_width(input int unsigned line_words);
    return $clog2(line_words);
  endfunction

  function automatic int unsigned index_width(input int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned tag_width(input int unsigned addr_width,
                                            input int unsigned data_width,
                                            input int unsigned line_words,
                                            input int unsigned sets);
    return addr_width - off_width(data_width) - word_width(line_words) - index_width(sets);
  endfunction

endpackage

// File: rtl/icache_sa_if.sv
// Fetch and refill-memory signal bundle of icache_sa; slave is the cache side.
interface icache_sa_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic [ADDR_WIDTH-1:0] i_addr;
  logic                  i_rd;
  logic                  i_flush;
  logic [DATA_WIDTH-1:0] o_inst;
  logic                  o_busy;
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic                  o_mem_rd;
  logic [DATA_WIDTH-1:0] i_mem_data;
  logic                  i_mem_valid;

  modport slave (
    input  i_addr, i_rd, i_flush, i_mem_data, i_mem_valid,
    output o_inst, o_busy, o_mem_addr, o_mem_rd
  );

  modport master (
    output i_addr, i_rd, i_flush, i_mem_data, i_mem_valid,
    input  o_inst, o_busy, o_mem_addr, o_mem_rd
  );
endinterface

// File: rtl/icache_way.sv
// One cache way: per-set valid bit and tag plus line data, combinational lookup.
module icache_way #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TAG_W      = 22,
  parameter int unsigned IDX_W      = 6,
  parameter int unsigned WORD_W     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IDX_W-1:0]      rd_idx,
  input  logic [WORD_W-1:0]     rd_word,
  input  logic [TAG_W-1:0]      rd_tag,
  output logic                  hit,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [WORD_W-1:0]     wr_word,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic                  word_we,
  input  logic                  tag_we,
  input  logic                  valid_clr
);
  localparam int unsigned SETS  = 1 << IDX_W;
  localparam int unsigned DEPTH = SETS << WORD_W;

  logic [SETS-1:0]       valid_q;
  logic [TAG_W-1:0]      tags [SETS];
  logic [DATA_WIDTH-1:0] mem  [DEPTH];

  assign valid   = valid_q[rd_idx];
  assign hit     = valid && (tags[rd_idx] == rd_tag);
  assign rd_data = mem[{rd_idx, rd_word}];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (valid_clr) begin
      valid_q[wr_idx] <= 1'b0;
    end else if (tag_we) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tag_we) tags[wr_idx] <= wr_tag;
    if (word_we) mem[{wr_idx, wr_word}] <= wr_data;
  end
endmodule

// File: rtl/icache_sa.sv
// Set-associative (1/2-way, LRU) instruction cache with line refill and full flush.
// Optional hit/miss counters are enabled by defining ICACHE_SA_STATS_EN.
module icache_sa
  import icache_sa_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned SETS       = 64,
  parameter int unsigned WAYS       = 2
) (
  input  logic        i_clock,
  input  logic        i_reset,
`ifdef ICACHE_SA_STATS_EN
  output logic [31:0] o_hits,
  output logic [31:0] o_misses,
`endif
  icache_sa_if.slave  bus
);
  localparam int unsigned OFF_W  = off_width(DATA_WIDTH);
  localparam int unsigned WORD_W = word_width(LINE_WORDS);
  localparam int unsigned IDX_W  = index_width(SETS);
  localparam int unsigned TAG_W  = tag_width(ADDR_WIDTH, DATA_WIDTH, LINE_WORDS, SETS);

  if (WAYS != 1 && WAYS != 2) begin : g_ways_check
    $error("icache_sa: WAYS must be 1 or 2");
  end

  if (OFF_W > 0) begin : g_off
    logic unused_off;
    assign unused_off = ^bus.i_addr[OFF_W-1:0];
  end

  state_t state, state_n;
  logic [TAG_W-1:0]  r_tag;
  logic [IDX_W-1:0]  r_idx;
  logic [WORD_W-1:0] cnt;
  logic [IDX_W-1:0]  fcnt;
  logic              vic, vic_n, pend;
  logic [SETS-1:0]   lru;

  logic [TAG_W-1:0]  a_tag;
  logic [IDX_W-1:0]  a_idx;
  logic [WORD_W-1:0] a_word;
  assign a_tag  = bus.i_addr[ADDR_WIDTH-1 -: TAG_W];
  assign a_idx  = bus.i_addr[OFF_W+WORD_W +: IDX_W];
  assign a_word = bus.i_addr[OFF_W +: WORD_W];

  logic [WAYS-1:0]       way_hit, way_valid, word_we, tag_we;
  logic [DATA_WIDTH-1:0] way_data [WAYS];
  logic [IDX_W-1:0]      way_idx;

  assign way_idx = (state == FLUSH) ? fcnt : r_idx;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    icache_way #(
      .DATA_WIDTH(DATA_WIDTH),
      .TAG_W     (TAG_W),
      .IDX_W     (IDX_W),
      .WORD_W    (WORD_W)
    ) u_way (
      .clk      (i_clock),
      .rst_n    (i_reset),
      .rd_idx   (a_idx),
      .rd_word  (a_word),
      .rd_tag   (a_tag),
      .hit      (way_hit[w]),
      .valid    (way_valid[w]),
      .rd_data  (way_data[w]),
      .wr_idx   (way_idx),
      .wr_word  (cnt),
      .wr_data  (bus.i_mem_data),
      .wr_tag   (r_tag),
      .word_we  (word_we[w]),
      .tag_we   (tag_we[w]),
      .valid_clr(state == FLUSH)
    );
  end

  logic                  lookup_hit, miss_start, refill_wr, last_word, hit_way;
  logic [DATA_WIDTH-1:0] hit_data;

  assign lookup_hit = (state == IDLE) && bus.i_rd && !bus.i_flush && (|way_hit);
  assign miss_start = (state == IDLE) && bus.i_rd && !bus.i_flush && !(|way_hit);
  assign refill_wr  = (state == REFILL) && bus.i_mem_valid;
  assign last_word  = refill_wr && (cnt == WORD_W'(LINE_WORDS - 1));

  // Victim: lowest-numbered invalid way wins over the LRU pointer.
  always_comb begin
    hit_data = '0;
    hit_way  = 1'b0;
    vic_n    = (WAYS == 2) ? lru[a_idx] : 1'b0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (way_hit[w]) begin
        hit_data = hit_data | way_data[w];
        hit_way  = 1'(w);
      end
      word_we[w] = refill_wr && (vic == 1'(w));
      tag_we[w]  = last_word && (vic == 1'(w));
    end
    for (int unsigned w = WAYS; w > 0; w--) begin
      if (!way_valid[w-1]) vic_n = 1'(w - 1);
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (bus.i_flush) state_n = FLUSH;
               else if (miss_start) state_n = REFILL;
      REFILL:  if (last_word) state_n = (pend || bus.i_flush) ? FLUSH : IDLE;
      FLUSH:   if (fcnt == IDX_W'(SETS - 1)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are forced to their reset values while reset is held.
  assign bus.o_busy     = i_reset && ((state != IDLE) || bus.i_flush || miss_start);
  assign bus.o_inst     = (i_reset && lookup_hit) ? hit_data : '0;
  assign bus.o_mem_rd   = i_reset && (state == REFILL);
  assign bus.o_mem_addr = bus.o_mem_rd ? (ADDR_WIDTH'({r_tag, r_idx, cnt}) << OFF_W) : '0;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state <= IDLE;
      r_tag <= '0;
      r_idx <= '0;
      vic   <= 1'b0;
      cnt   <= '0;
      fcnt  <= '0;
      pend  <= 1'b0;
      lru   <= '0;
    end else begin
      state <= state_n;
      if (miss_start) begin
        r_tag <= a_tag;
        r_idx <= a_idx;
        vic   <= vic_n;
        cnt   <= '0;
      end
      if (state == REFILL) begin
        if (bus.i_mem_valid) cnt <= cnt + 1'b1;
        if (bus.i_flush) pend <= 1'b1;
        if (last_word) pend <= 1'b0;
      end
      if (state == FLUSH) begin
        fcnt      <= fcnt + 1'b1;
        lru[fcnt] <= 1'b0;
      end
      if (WAYS == 2) begin
        if (lookup_hit) lru[a_idx] <= ~hit_way;
        if (last_word) lru[r_idx] <= ~vic;
      end
    end
  end

`ifdef ICACHE_SA_STATS_EN
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_hits   <= '0;
      o_misses <= '0;
    end else if (state == FLUSH) begin
      o_hits   <= '0;
      o_misses <= '0;
    end else begin
      if (lookup_hit && (o_hits != '1)) o_hits <= o_hits + 1'b1;
      if (miss_start && (o_misses != '1)) o_misses <= o_misses + 1'b1;
    end
  end
`endif
endmodule
